// File: rtl/mau_pkg.sv
// Shared encodings for the MIPS MEM-stage load/store unit: access sizes,
// FSM states and byte-lane indices.
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_RMW_MERGE
  } state_t;

  // Encoding 11 is treated as a word access.
  function automatic logic is_word_size(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Lane selection with sign/zero extension for loads; the same lane decode
// yields the byte-lane mask and shift used to insert store data on RMW.
module mau_load_align
  import mau_pkg::*;
#(
  parameter int LEN_DATA = 32
) (
  input  logic [LEN_DATA-1:0] word,
  input  logic [1:0]          lane,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic [LEN_DATA-1:0] data_ext,
  output logic [LEN_DATA-1:0] lane_mask,
  output logic [4:0]          shift
);

  logic [1:0]          eff_lane;
  logic [LEN_DATA-1:0] shifted;

  always_comb begin
    eff_lane  = lane;
    data_ext  = word;
    lane_mask = '1;
    // Offending low address bits are dropped: halves use addr[1], words lane 0.
    if (is_word_size(size))
      eff_lane = LANE_0;
    else if (size == SIZE_HALF)
      eff_lane = {lane[1], 1'b0};
    shift   = {eff_lane, 3'b000};
    shifted = word >> shift;
    if (size == SIZE_BYTE) begin
      data_ext  = {{(LEN_DATA-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      lane_mask = {{(LEN_DATA-8){1'b0}}, 8'hFF} << shift;
    end else if (size == SIZE_HALF) begin
      data_ext  = {{(LEN_DATA-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      lane_mask = {{(LEN_DATA-16){1'b0}}, 16'hFFFF} << shift;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word stores go straight through, loads and
// sub-word stores take a read round-trip. Optional MAU_ALIGN_CHECK_EN flags
// misaligned half/word requests instead of accessing memory.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int LEN_DATA = 32,
  parameter int LEN_ADDR = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [LEN_ADDR+1:0] req_addr,
  input  logic [LEN_DATA-1:0] req_wdata,
  output logic                stall,
  output logic [LEN_DATA-1:0] rdata,
  output logic                rdata_valid,
  output logic                misaligned,
  output logic [LEN_ADDR-1:0] mem_addr,
  output logic [LEN_DATA-1:0] mem_din,
  output logic                mem_wr,
  output logic                mem_rd,
  input  logic [LEN_DATA-1:0] mem_dout
);

  state_t              state, state_nxt;
  logic                mis_req;
  logic                stall_c, wr_c, rd_c;
  logic [LEN_DATA-1:0] din_c;
  logic [LEN_DATA-1:0] load_ext, lane_mask, merged;
  logic [4:0]          shift;

  mau_load_align #(.LEN_DATA(LEN_DATA)) u_align (
    .word       (mem_dout),
    .lane       (req_addr[1:0]),
    .size       (req_size),
    .is_unsigned(req_unsigned),
    .data_ext   (load_ext),
    .lane_mask  (lane_mask),
    .shift      (shift)
  );

  assign merged = (mem_dout & ~lane_mask) | ((req_wdata << shift) & lane_mask);

`ifdef MAU_ALIGN_CHECK_EN
  assign mis_req = (req_rd | req_wr) &&
                   (((req_size == SIZE_HALF) && req_addr[0]) ||
                    (is_word_size(req_size) && (req_addr[1:0] != LANE_0)));
`else
  assign mis_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    wr_c      = 1'b0;
    rd_c      = 1'b0;
    din_c     = req_wdata;
    case (state)
      ST_IDLE: begin
        if (!mis_req) begin
          if (req_wr) begin
            if (is_word_size(req_size)) begin
              wr_c = 1'b1;
            end else begin
              rd_c      = 1'b1;
              stall_c   = 1'b1;
              state_nxt = ST_RMW_MERGE;
            end
          end else if (req_rd) begin
            rd_c      = 1'b1;
            stall_c   = 1'b1;
            state_nxt = ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: state_nxt = ST_IDLE;
      ST_RMW_MERGE: begin
        wr_c      = 1'b1;
        din_c     = merged;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gating by rst_n drops strobes the instant reset asserts, abandoning any RMW.
  assign stall      = stall_c & rst_n;
  assign mem_wr     = wr_c & rst_n;
  assign mem_rd     = rd_c & rst_n;
  assign misaligned = mis_req & rst_n & (state == ST_IDLE);
  assign mem_din    = din_c;
  assign mem_addr   = req_addr[LEN_ADDR+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= (state == ST_LOAD_WAIT);
      if (state == ST_LOAD_WAIT) rdata <= load_ext;
    end
  end

endmodule
